// File: rtl/mac_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mac_pkg : shared types and constants for the round-robin MAC scheduler    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package mac_pkg;

   localparam int DW_DEFAULT     = 256;
   localparam int ENGINE_LATENCY = 258;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_ACCUM = 3'd3;
   localparam logic [2:0] ST_RESP  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_ISSUE = ST_ISSUE,
      S_WAIT  = ST_WAIT,
      S_ACCUM = ST_ACCUM,
      S_RESP  = ST_RESP
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rca.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | RCA : parameterised ripple-carry adder                                    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module RCA #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic c;

   always_comb begin
      c   = cin;
      sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, first request at/after ptr   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   logic [PW-1:0] idx;

   // Scan from farthest to nearest so the last hit is the closest to ptr.
   always_comb begin
      grant = '0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = PW'((int'(ptr) + i) % N);
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mac_rr_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mac_rr_scheduler : shares one multiplier among NREQ accumulating clients  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module mac_rr_scheduler
   import mac_pkg::*;
#(
   parameter  int NREQ    = 4,
   parameter  int DW      = DW_DEFAULT,
   parameter  int TIMEOUT = 300,
   localparam int IW      = $clog2(NREQ),
   localparam int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ-1:0]    req_clr,
   input  logic [NREQ*DW-1:0] req_a,
   input  logic [NREQ*DW-1:0] req_b,
   output logic               mul_start,
   output logic [DW-1:0]      mul_a,
   output logic [DW-1:0]      mul_b,
   input  logic               mul_done,
   input  logic [2*DW-1:0]    mul_product,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [IW-1:0]      resp_id,
   output logic [2*DW-1:0]    resp_acc,
   output logic               resp_err,
   output logic               busy
);

   state_t           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    id_q, id_d;
   logic [DW-1:0]    a_q, a_d;
   logic [DW-1:0]    b_q, b_d;
   logic             clr_q, clr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2*DW-1:0]  prod_q, prod_d;
   logic             err_q, err_d;
   logic [2*DW-1:0]  resp_acc_q, resp_acc_d;
   logic [2*DW-1:0]  acc_q [NREQ];
   logic [2*DW-1:0]  acc_d [NREQ];

   logic [NREQ-1:0]  grant;
   logic [IW-1:0]    gidx;
   logic [2*DW-1:0]  add_base;
   logic [2*DW-1:0]  add_sum;
   logic             acc_cout_unused;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (grant)
   );

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) gidx = IW'(i);
      end
   end

   assign add_base = clr_q ? '0 : acc_q[id_q];

   RCA #(.WIDTH(2*DW)) u_acc_add (
      .a    (add_base),
      .b    (prod_q),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (acc_cout_unused)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      a_d        = a_q;
      b_d        = b_q;
      clr_d      = clr_q;
      cnt_d      = cnt_q;
      prod_d     = prod_q;
      err_d      = err_q;
      resp_acc_d = resp_acc_q;
      acc_d      = acc_q;
      case (state_q)
         S_IDLE: begin
            if (|req_valid) begin
               a_d     = req_a[gidx*DW +: DW];
               b_d     = req_b[gidx*DW +: DW];
               clr_d   = req_clr[gidx];
               id_d    = gidx;
               err_d   = 1'b0;
               ptr_d   = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (mul_done) begin
               prod_d  = mul_product;
               state_d = S_ACCUM;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               // Abort leaves the accumulator (and its clr request) untouched.
               err_d      = 1'b1;
               resp_acc_d = acc_q[id_q];
               state_d    = S_RESP;
            end
         end
         S_ACCUM: begin
            acc_d[id_q] = add_sum;
            resp_acc_d  = add_sum;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         id_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         clr_q      <= 1'b0;
         cnt_q      <= '0;
         prod_q     <= '0;
         err_q      <= 1'b0;
         resp_acc_q <= '0;
         for (int i = 0; i < NREQ; i++) acc_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         a_q        <= a_d;
         b_q        <= b_d;
         clr_q      <= clr_d;
         cnt_q      <= cnt_d;
         prod_q     <= prod_d;
         err_q      <= err_d;
         resp_acc_q <= resp_acc_d;
         acc_q      <= acc_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE) ? grant : '0;
   assign mul_start  = (state_q == S_ISSUE);
   assign mul_a      = a_q;
   assign mul_b      = b_q;
   assign resp_valid = (state_q == S_RESP);
   assign resp_id    = id_q;
   assign resp_acc   = resp_acc_q;
   assign resp_err   = err_q;
   assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mac_rr_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mac_rr_scheduler : randomized bench with transaction-level model       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_mac_rr_scheduler;

   localparam int NREQ    = 4;
   localparam int DW      = 256;
   localparam int TIMEOUT = 300;
   localparam int L       = 258;
   localparam int IW      = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    req_clr;
   logic [NREQ*DW-1:0] req_a;
   logic [NREQ*DW-1:0] req_b;
   logic               mul_start;
   logic [DW-1:0]      mul_a;
   logic [DW-1:0]      mul_b;
   logic               mul_done;
   logic [2*DW-1:0]    mul_product;
   logic               resp_valid;
   logic               resp_ready;
   logic [IW-1:0]      resp_id;
   logic [2*DW-1:0]    resp_acc;
   logic               resp_err;
   logic               busy;

   mac_rr_scheduler #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_clr     (req_clr),
      .req_a       (req_a),
      .req_b       (req_b),
      .mul_start   (mul_start),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_done    (mul_done),
      .mul_product (mul_product),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_id     (resp_id),
      .resp_acc    (resp_acc),
      .resp_err    (resp_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
         if (errors >= 30) begin
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s at cycle %0d: got no event expected event", nm, cyc);
   endtask

   function automatic logic [DW-1:0] rand_w();
      logic [DW-1:0] v;
      v = '0;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
      for (int i = 0; i < NREQ; i++) begin
         if (r[(p + i) % NREQ]) return (p + i) % NREQ;
      end
      return -1;
   endfunction

   // Engine: product a*b delivered L cycles after the start pulse.
   bit eng_on    = 1'b1;
   bit stray_req = 1'b0;
   initial begin : engine
      longint due;
      logic [511:0] eprod;
      due = -1;
      eprod = '0;
      mul_done = 1'b0;
      mul_product = '0;
      forever begin
         @(posedge clk);
         #1;
         mul_done = 1'b0;
         if (mul_start && eng_on) begin
            due   = cyc + L;
            eprod = {256'b0, mul_a} * {256'b0, mul_b};
         end
         if (cyc == due) begin
            mul_done    = 1'b1;
            mul_product = eprod;
            due         = -1;
         end else if (stray_req) begin
            mul_done    = 1'b1;
            mul_product = {rand_w(), rand_w()};
            stray_req   = 1'b0;
         end
      end
   end

   bit rr_rand  = 1'b0;
   bit rr_fixed = 1'b1;
   initial begin : resp_drv
      resp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
      end
   end

   // Transaction-level reference model and per-cycle compare.
   bit           armed = 1'b0;
   bit           inflight = 1'b0;
   int           m_ptr = 0;
   int           m_id = 0;
   logic [511:0] m_acc [NREQ];
   logic [511:0] m_resp_acc = '0;
   bit           m_err = 1'b0;
   logic [DW-1:0] ma_m = '0, mb_m = '0;
   longint       t_acc = 0, t_resp = 0, dut_rise = -1, dut_start = -1;
   int           n_acc = 0, n_resp = 0;
   int           grant_log [$];
   logic [511:0] last_acc = '0;
   bit           last_err = 1'b0;
   int           last_id = 0;
   longint       last_lat = 0, last_start_lat = 0;

   initial begin : model
      int pick;
      logic [NREQ-1:0] exp_rdy;
      logic [DW-1:0] a_in, b_in;
      for (int i = 0; i < NREQ; i++) m_acc[i] = '0;
      forever begin
         @(negedge clk);
         pick = rr_pick(req_valid, m_ptr);
         if (armed) begin
            if (!inflight) begin
               exp_rdy = '0;
               if (pick >= 0) exp_rdy[pick] = 1'b1;
               chk("req_ready", req_ready, exp_rdy);
               chk("busy_idle", busy, 0);
               chk("mul_start_idle", mul_start, 0);
               chk("resp_valid_idle", resp_valid, 0);
            end else begin
               chk("busy", busy, 1);
               chk("req_ready_busy", req_ready, 0);
               chk("mul_start", mul_start, (cyc == t_acc + 1));
               chk("resp_valid", resp_valid, (cyc >= t_resp));
               if (mul_start && dut_start < 0) dut_start = cyc;
               if (resp_valid && dut_rise < 0) dut_rise = cyc;
               if (cyc >= t_resp) begin
                  chk("resp_id", resp_id, m_id);
                  chk("resp_acc", resp_acc, m_resp_acc);
                  chk("resp_err", resp_err, m_err);
               end
            end
            chk("mul_a", mul_a, ma_m);
            chk("mul_b", mul_b, mb_m);
         end
         if (rst) begin
            armed    = 1'b1;
            inflight = 1'b0;
            m_ptr    = 0;
            ma_m     = '0;
            mb_m     = '0;
            for (int i = 0; i < NREQ; i++) m_acc[i] = '0;
         end else if (armed) begin
            if (!inflight && pick >= 0) begin
               a_in      = req_a[pick*DW +: DW];
               b_in      = req_b[pick*DW +: DW];
               inflight  = 1'b1;
               t_acc     = cyc;
               dut_rise  = -1;
               dut_start = -1;
               m_id      = pick;
               m_ptr     = (pick + 1) % NREQ;
               ma_m      = a_in;
               mb_m      = b_in;
               if (eng_on) begin
                  m_acc[pick] = (req_clr[pick] ? 512'd0 : m_acc[pick])
                                + {256'b0, a_in} * {256'b0, b_in};
                  m_err  = 1'b0;
                  t_resp = t_acc + 3 + L;
               end else begin
                  m_err  = 1'b1;
                  t_resp = t_acc + TIMEOUT + 2;
               end
               m_resp_acc = m_acc[pick];
               grant_log.push_back(pick);
               n_acc++;
            end else if (inflight && cyc >= t_resp && resp_ready) begin
               inflight       = 1'b0;
               last_acc       = resp_acc;
               last_err       = resp_err;
               last_id        = int'(resp_id);
               last_lat       = dut_rise - t_acc;
               last_start_lat = dut_start - t_acc;
               n_resp++;
            end
         end
      end
   end

   task automatic issue(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit clr);
      int na;
      int k;
      na = n_acc;
      k  = 0;
      @(posedge clk);
      #1;
      req_valid[id]        = 1'b1;
      req_a[id*DW +: DW]   = a;
      req_b[id*DW +: DW]   = b;
      req_clr[id]          = clr;
      while (n_acc == na && k < 1500) begin
         @(posedge clk);
         #1;
         k++;
      end
      req_valid[id] = 1'b0;
      if (n_acc == na) fail_now("accept_timeout");
   endtask

   task automatic wait_resp(input int nr);
      int k;
      k = 0;
      while (n_resp == nr && k < 2000) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (n_resp == nr) fail_now("resp_timeout");
   endtask

   task automatic do_op(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit clr);
      int nr;
      nr = n_resp;
      issue(id, a, b, clr);
      wait_resp(nr);
   endtask

   initial begin : watchdog
      repeat (80000) @(posedge clk);
      fail_now("watchdog");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : stim
      logic [DW-1:0] ones;
      int exp_order [5];
      int base_g, base_a, base_r, seen, g, k;
      ones = '1;
      exp_order = '{0, 1, 2, 3, 0};
      rst = 1'b1;
      req_valid = '0;
      req_clr = '0;
      req_a = '0;
      req_b = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_mul_start", mul_start, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_resp_acc", resp_acc, 0);
      chk("rst_resp_err", resp_err, 0);

      // 1: single request, latency
      do_op(0, 3, 5, 1'b1);
      chk("t1_acc", last_acc, 15);
      chk("t1_err", last_err, 0);
      chk("t1_id", last_id, 0);
      chk("t1_lat", last_lat, 261);
      chk("t1_start", last_start_lat, 1);

      // 2: accumulate then clear
      do_op(0, 2, 7, 1'b0);
      chk("t2_acc29", last_acc, 29);
      do_op(0, 1, 1, 1'b1);
      chk("t2_acc1", last_acc, 1);

      // 3: all requesters held valid from reset
      base_g = grant_log.size();
      base_r = n_resp;
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*DW +: DW] = rand_w();
         req_b[i*DW +: DW] = rand_w();
         req_clr[i]        = 1'($urandom_range(0, 1));
      end
      req_valid = '1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      base_a = n_acc;
      seen = n_acc;
      k = 0;
      while (n_acc - base_a < 5 && k < 3000) begin
         @(posedge clk);
         #1;
         k++;
         if (n_acc != seen) begin
            seen = n_acc;
            g = grant_log[$];
            req_a[g*DW +: DW] = rand_w();
            req_b[g*DW +: DW] = rand_w();
            req_clr[g]        = 1'($urandom_range(0, 1));
         end
      end
      req_valid = '0;
      if (n_acc - base_a < 5) fail_now("t3_accepts");
      k = 0;
      while (n_resp - base_r < 5 && k < 3000) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (n_resp - base_r < 5) fail_now("t3_resps");
      for (int i = 0; i < 5; i++) begin
         if (grant_log.size() > base_g + i)
            chk($sformatf("t3_grant%0d", i), grant_log[base_g + i], exp_order[i]);
      end

      // 4: accumulator wraps modulo 2^512
      do_op(1, ones, ones, 1'b1);
      do_op(1, 2, ones, 1'b0);
      chk("t4_allones", last_acc, {512{1'b1}});
      do_op(1, 1, 1, 1'b0);
      chk("t4_wrap", last_acc, 0);

      // 5: engine timeout
      do_op(2, 6, 7, 1'b1);
      chk("t5_pre", last_acc, 42);
      eng_on = 1'b0;
      do_op(2, 5, 5, 1'b1);
      chk("t5_err", last_err, 1);
      chk("t5_acc_kept", last_acc, 42);
      chk("t5_lat", last_lat, TIMEOUT + 2);
      eng_on = 1'b1;
      do_op(2, 1, 1, 1'b0);
      chk("t5_next_acc", last_acc, 43);
      chk("t5_next_err", last_err, 0);

      // random traffic with random backpressure
      rr_rand = 1'b1;
      repeat (6) do_op(int'($urandom_range(0, NREQ - 1)), rand_w(), rand_w(), 1'($urandom_range(0, 1)));
      rr_rand = 1'b0;
      rr_fixed = 1'b1;
      @(posedge clk);
      #1;

      // 6: response backpressure
      rr_fixed = 1'b0;
      @(posedge clk);
      #1;
      base_r = n_resp;
      issue(3, 9, 9, 1'b1);
      req_valid[1]      = 1'b1;
      req_a[1*DW +: DW] = 1;
      req_b[1*DW +: DW] = 1;
      req_clr[1]        = 1'b1;
      k = 0;
      while (!resp_valid && k < 600) begin
         @(negedge clk);
         k++;
      end
      if (!resp_valid) fail_now("t6_resp_rise");
      repeat (10) @(negedge clk);
      chk("t6_hold_valid", resp_valid, 1);
      chk("t6_hold_acc", resp_acc, 81);
      chk("t6_hold_id", resp_id, 3);
      chk("t6_hold_rdy", req_ready, 0);
      base_a = n_acc;
      @(posedge clk);
      #1;
      rr_fixed = 1'b1;
      k = 0;
      while (n_acc == base_a && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      req_valid[1] = 1'b0;
      if (n_acc == base_a) fail_now("t6_req1_accept");
      wait_resp(base_r + 1);
      chk("t6_req1_acc", last_acc, 1);

      // reset in the middle of WAIT, then stray done pulses
      issue(0, 3, 3, 1'b0);
      repeat (50) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_valid", resp_valid, 0);
      chk("t6_rst_acc", resp_acc, 0);
      chk("t6_rst_mul_a", mul_a, 0);
      stray_req = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      do_op(2, 4, 4, 1'b0);
      chk("t6_acc2_cleared", last_acc, 16);
      do_op(0, 1, 1, 1'b0);
      chk("t6_acc0_cleared", last_acc, 1);

      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
